sr_muldiv: RTL and testbench



---
 rtl/sr_muldiv_pkg.sv | 44 ++++
 rtl/sr_muldiv_fix.sv | 65 ++++++
 rtl/sr_muldiv.sv | 174 +++++++++++++++++
 tb/tb_sr_muldiv.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sr_muldiv_pkg.sv
// Shared encodings for the schoolRISCV iterative multiply/divide unit.
// Operation codes match the RV32M funct3 field.
package sr_muldiv_pkg;

    typedef enum logic [2:0] {
        MDU_MUL    = 3'b000,
        MDU_MULH   = 3'b001,
        MDU_MULHSU = 3'b010,
        MDU_MULHU  = 3'b011,
        MDU_DIV    = 3'b100,
        MDU_DIVU   = 3'b101,
        MDU_REM    = 3'b110,
        MDU_REMU   = 3'b111
    } mdu_op_e;

    typedef enum logic [1:0] {
        MDU_IDLE = 2'b00,
        MDU_CALC = 2'b01,
        MDU_FIX  = 2'b10,
        MDU_DONE = 2'b11
    } mdu_state_e;

    localparam logic [6:0] RVF7_MULDIV = 7'b0000001;

    function automatic logic op_is_div(input logic [2:0] op);
        op_is_div = op[2];
    endfunction

    // srcA is two's complement for MULH, MULHSU, DIV and REM
    function automatic logic op_signed_a(input logic [2:0] op);
        case (op)
            MDU_MULH, MDU_MULHSU, MDU_DIV, MDU_REM: op_signed_a = 1'b1;
            default:                               op_signed_a = 1'b0;
        endcase
    endfunction

    function automatic logic op_signed_b(input logic [2:0] op);
        case (op)
            MDU_MULH, MDU_DIV, MDU_REM: op_signed_b = 1'b1;
            default:                    op_signed_b = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/sr_muldiv_fix.sv
// Combinational sign correction and result selection for sr_muldiv.
// The RISC-V divide special cases override the iterated value here.
module sr_muldiv_fix
    import sr_muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]        op,
    input  logic [2*XLEN-1:0] acc,
    input  logic              neg_res,
    input  logic              neg_rem,
    input  logic              div_zero,
    input  logic              div_ovf,
    input  logic [XLEN-1:0]   src_a,
    output logic [XLEN-1:0]   result
);

    logic [2*XLEN-1:0] prod_s;
    logic [XLEN-1:0]   quo_s;
    logic [XLEN-1:0]   rem_s;

    // Negate magnitudes where needed, then pick the half/part the op asks for
    always_comb begin
        prod_s = acc;
        quo_s  = acc[XLEN-1:0];
        rem_s  = acc[2*XLEN-1:XLEN];
        result = {XLEN{1'b0}};
        if (neg_res) begin
            prod_s = (~acc) + (2*XLEN)'(1'b1);
            quo_s  = (~acc[XLEN-1:0]) + XLEN'(1'b1);
        end else begin
            prod_s = acc;
            quo_s  = acc[XLEN-1:0];
        end
        if (neg_rem) begin
            rem_s = (~acc[2*XLEN-1:XLEN]) + XLEN'(1'b1);
        end else begin
            rem_s = acc[2*XLEN-1:XLEN];
        end
        case (op)
            MDU_MUL:                         result = prod_s[XLEN-1:0];
            MDU_MULH, MDU_MULHSU, MDU_MULHU: result = prod_s[2*XLEN-1:XLEN];
            MDU_DIV, MDU_DIVU: begin
                if (div_zero) begin
                    result = {XLEN{1'b1}};
                end else if (div_ovf) begin
                    result = src_a;
                end else begin
                    result = quo_s;
                end
            end
            MDU_REM, MDU_REMU: begin
                if (div_zero) begin
                    result = src_a;
                end else if (div_ovf) begin
                    result = {XLEN{1'b0}};
                end else begin
                    result = rem_s;
                end
            end
            default: result = {XLEN{1'b0}};
        endcase
    end

endmodule

// File: rtl/sr_muldiv.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and
// restoring divide, one bit per cycle, behind a start/ready/done handshake.
module sr_muldiv
    import sr_muldiv_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter bit EARLY_OUT = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] srcA,
    input  logic [XLEN-1:0] srcB,
    input  logic            kill,
    output logic            ready,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CNT_W = $clog2(XLEN) + 1;

    mdu_state_e        state_r, state_next_s;
    logic [2:0]        op_r;
    logic              neg_res_r, neg_rem_r, div_zero_r, div_ovf_r;
    logic [XLEN-1:0]   src_a_r, opd_b_r;
    logic [CNT_W-1:0]  cnt_r;
    logic [2*XLEN-1:0] acc_r;
    logic              ready_r, done_r;
    logic [XLEN-1:0]   result_r;

    logic              accept_s, early_s;
    logic              sign_a_s, sign_b_s, div_zero_s, div_ovf_s;
    logic [XLEN-1:0]   mag_a_s, mag_b_s;
    logic [XLEN:0]     mul_sum_s, rem_shift_s, diff_s;
    logic [2*XLEN-1:0] step_s;
    logic [XLEN-1:0]   fix_result_s;

    // Operand decode at acceptance: magnitudes, sign flags and special cases
    always_comb begin
        accept_s   = (state_r == MDU_IDLE) && start && !kill;
        sign_a_s   = op_signed_a(op) & srcA[XLEN-1];
        sign_b_s   = op_signed_b(op) & srcB[XLEN-1];
        mag_a_s    = sign_a_s ? ((~srcA) + XLEN'(1'b1)) : srcA;
        mag_b_s    = sign_b_s ? ((~srcB) + XLEN'(1'b1)) : srcB;
        div_zero_s = op_is_div(op) && (srcB == {XLEN{1'b0}});
        div_ovf_s  = op_is_div(op) && op_signed_b(op)
                     && (srcA == {1'b1, {(XLEN-1){1'b0}}})
                     && (srcB == {XLEN{1'b1}});
        early_s    = EARLY_OUT && (div_zero_s || div_ovf_s);
    end

    // One radix-2 iteration; divide shifts the next dividend bit into the remainder
    always_comb begin
        mul_sum_s   = {1'b0, acc_r[2*XLEN-1:XLEN]}
                      + (acc_r[0] ? {1'b0, opd_b_r} : {(XLEN+1){1'b0}});
        rem_shift_s = acc_r[2*XLEN-1:XLEN-1];
        diff_s      = rem_shift_s - {1'b0, opd_b_r};
        if (op_is_div(op_r)) begin
            if (diff_s[XLEN]) begin
                step_s = {rem_shift_s[XLEN-1:0], acc_r[XLEN-2:0], 1'b0};
            end else begin
                step_s = {diff_s[XLEN-1:0], acc_r[XLEN-2:0], 1'b1};
            end
        end else begin
            step_s = {mul_sum_s, acc_r[XLEN-1:1]};
        end
    end

    // Next-state logic; kill aborts any busy state except DONE
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            MDU_IDLE: begin
                if (accept_s) begin
                    state_next_s = early_s ? MDU_FIX : MDU_CALC;
                end else begin
                    state_next_s = MDU_IDLE;
                end
            end
            MDU_CALC: begin
                if (kill) begin
                    state_next_s = MDU_IDLE;
                end else if (cnt_r == CNT_W'(XLEN - 1)) begin
                    state_next_s = MDU_FIX;
                end else begin
                    state_next_s = MDU_CALC;
                end
            end
            MDU_FIX: begin
                if (kill) begin
                    state_next_s = MDU_IDLE;
                end else begin
                    state_next_s = MDU_DONE;
                end
            end
            MDU_DONE: state_next_s = MDU_IDLE;
            default:  state_next_s = MDU_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= MDU_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Datapath: operand load on acceptance, accumulator update while iterating
    always_ff @(posedge clk) begin
        if (rst) begin
            op_r       <= 3'b000;
            neg_res_r  <= 1'b0;
            neg_rem_r  <= 1'b0;
            div_zero_r <= 1'b0;
            div_ovf_r  <= 1'b0;
            src_a_r    <= {XLEN{1'b0}};
            opd_b_r    <= {XLEN{1'b0}};
            cnt_r      <= {CNT_W{1'b0}};
            acc_r      <= {(2*XLEN){1'b0}};
        end else if (accept_s) begin
            op_r       <= op;
            neg_res_r  <= sign_a_s ^ sign_b_s;
            neg_rem_r  <= sign_a_s;
            div_zero_r <= div_zero_s;
            div_ovf_r  <= div_ovf_s;
            src_a_r    <= srcA;
            cnt_r      <= {CNT_W{1'b0}};
            if (op_is_div(op)) begin
                acc_r   <= {{XLEN{1'b0}}, mag_a_s};
                opd_b_r <= mag_b_s;
            end else begin
                acc_r   <= {{XLEN{1'b0}}, mag_b_s};
                opd_b_r <= mag_a_s;
            end
        end else if (state_r == MDU_CALC) begin
            acc_r <= step_s;
            cnt_r <= cnt_r + CNT_W'(1'b1);
        end
    end

    sr_muldiv_fix #(.XLEN(XLEN)) u_fix (
        .op       (op_r),
        .acc      (acc_r),
        .neg_res  (neg_res_r),
        .neg_rem  (neg_rem_r),
        .div_zero (div_zero_r),
        .div_ovf  (div_ovf_r),
        .src_a    (src_a_r),
        .result   (fix_result_s)
    );

    // Registered handshake and result; a killed FIX leaves the result untouched
    always_ff @(posedge clk) begin
        if (rst) begin
            ready_r  <= 1'b1;
            done_r   <= 1'b0;
            result_r <= {XLEN{1'b0}};
        end else begin
            ready_r <= (state_next_s == MDU_IDLE);
            done_r  <= (state_r == MDU_FIX) && !kill;
            if ((state_r == MDU_FIX) && !kill) begin
                result_r <= fix_result_s;
            end
        end
    end

    assign ready  = ready_r;
    assign done   = done_r;
    assign result = result_r;

endmodule

// File: tb/tb_sr_muldiv.sv
// Scoreboard bench for sr_muldiv (XLEN=32, EARLY_OUT=1): expected results and
// done cycles are queued at start and compared when done pulses.
module tb_sr_muldiv;

    localparam int XLEN      = 32;
    localparam bit EARLY_OUT = 1'b1;

    logic              clk = 1'b0;
    logic              rst, start, kill;
    logic [2:0]        op;
    logic [XLEN-1:0]   srcA, srcB;
    logic              ready, done;
    logic [XLEN-1:0]   result;

    int n_checks = 0;
    int n_fails  = 0;
    int cyc      = 0;

    typedef struct {
        logic [31:0] res;
        int          due;
    } sb_t;
    sb_t         sb_q[$];
    logic [31:0] last_result;

    sr_muldiv #(.XLEN(XLEN), .EARLY_OUT(EARLY_OUT)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op     (op),
        .srcA   (srcA),
        .srcB   (srcB),
        .kill   (kill),
        .ready  (ready),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [31:0] ref_model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sp;
        logic [63:0]        up;
        int                 sa, sb;
        logic [31:0]        r;
        sa = a;
        sb = b;
        up = {32'h0, a} * {32'h0, b};
        r  = 32'h0;
        case (o)
            3'b000: r = up[31:0];
            3'b001: begin
                sp = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
                r  = sp[63:32];
            end
            3'b010: begin
                sp = $signed({{32{a[31]}}, a}) * $signed({32'h0, b});
                r  = sp[63:32];
            end
            3'b011: r = up[63:32];
            3'b100: begin
                if (b == 32'h0) r = 32'hFFFFFFFF;
                else if (a == 32'h80000000 && b == 32'hFFFFFFFF) r = a;
                else r = sa / sb;
            end
            3'b101: r = (b == 32'h0) ? 32'hFFFFFFFF : a / b;
            3'b110: begin
                if (b == 32'h0) r = a;
                else if (a == 32'h80000000 && b == 32'hFFFFFFFF) r = 32'h0;
                else r = sa % sb;
            end
            default: r = (b == 32'h0) ? a : a % b;
        endcase
        return r;
    endfunction

    function automatic int exp_latency(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        if (EARLY_OUT && o[2] && (b == 32'h0 || (!o[0] && a == 32'h80000000 && b == 32'hFFFFFFFF)))
            return 2;
        return XLEN + 2;
    endfunction

    // Done monitor: every pulse must match the oldest queued expectation
    always @(negedge clk) begin
        if (done !== 1'b0) begin
            if (sb_q.size() == 0) begin
                check_value("done_unexpected", {63'h0, done}, 64'h0);
            end else begin
                sb_t e;
                e = sb_q.pop_front();
                check_value("result", {32'h0, result}, {32'h0, e.res});
                check_value("done_cycle", cyc, e.due);
                last_result = e.res;
            end
        end
    end

    task automatic wait_ready();
        int w;
        w = 0;
        while (ready !== 1'b1 && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (w == 100) check_value("ready_timeout", {63'h0, ready}, 64'h1);
    endtask

    // Issue one op at a negedge; optionally try a second start at cycle T+second_at
    task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int second_at);
        int  lat, c;
        sb_t e;
        wait_ready();
        lat   = exp_latency(o, a, b);
        c     = cyc;
        start = 1'b1;
        op    = o;
        srcA  = a;
        srcB  = b;
        e.res = exp;
        e.due = c + lat;
        sb_q.push_back(e);
        @(negedge clk);
        start = 1'b0;
        op    = 3'($urandom);
        srcA  = $urandom;
        srcB  = $urandom;
        for (int i = 1; i <= lat; i++) begin
            check_value({tag, "_ready_busy"}, {63'h0, ready}, 64'h0);
            if (i == second_at) begin
                start = 1'b1;
                op    = 3'b000;
                srcA  = 32'h3;
                srcB  = 32'h3;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        check_value({tag, "_ready_idle"}, {63'h0, ready}, 64'h1);
        check_value({tag, "_done_seen"}, sb_q.size(), 0);
        sb_q.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a, b;
        logic [2:0]  o;
        int          c;
        rst = 1'b1; start = 1'b0; kill = 1'b0; op = 3'b000; srcA = 32'h0; srcB = 32'h0;
        last_result = 32'h0;
        repeat (3) @(negedge clk);
        check_value("rst_ready",  {63'h0, ready}, 64'h1);
        check_value("rst_done",   {63'h0, done}, 64'h0);
        check_value("rst_result", {32'h0, result}, 64'h0);
        rst = 1'b0;
        @(negedge clk);

        run_op("mul",    3'b000, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFEB, 0);
        run_op("mulh",   3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 0);
        run_op("mulhu",  3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 0);
        run_op("mulhsu", 3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);
        run_op("div",    3'b100, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 0);
        run_op("rem",    3'b110, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 0);
        run_op("divu",   3'b101, 32'd100,      32'd7,        32'd14,       5);
        run_op("remu",   3'b111, 32'd100,      32'd7,        32'd2,        0);
        run_op("div0",   3'b100, 32'd5,        32'd0,        32'hFFFFFFFF, 0);
        run_op("rem0",   3'b110, 32'd5,        32'd0,        32'd5,        0);
        run_op("divu0",  3'b101, 32'd9,        32'd0,        32'hFFFFFFFF, 0);
        run_op("divovf", 3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 0);
        run_op("removf", 3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 0);

        for (int k = 0; k < 16; k++) begin
            o = 3'(k);
            a = $urandom;
            b = (k >= 8) ? 32'($urandom_range(1, 1000)) : $urandom;
            run_op("rand", o, a, b, ref_model(o, a, b), 0);
        end

        // Kill mid-calculation: no done, back to idle one cycle later
        wait_ready();
        c = cyc;
        start = 1'b1; op = 3'b000; srcA = 32'h1234; srcB = 32'h5678;
        @(negedge clk);
        start = 1'b0;
        while (cyc < c + 10) @(negedge clk);
        kill = 1'b1;
        @(negedge clk);
        kill = 1'b0;
        check_value("kill_ready",  {63'h0, ready}, 64'h1);
        check_value("kill_done",   {63'h0, done}, 64'h0);
        check_value("kill_result", {32'h0, result}, {32'h0, last_result});
        repeat (40) @(negedge clk);

        // Kill together with start in IDLE: nothing accepted
        kill = 1'b1; start = 1'b1; op = 3'b101; srcA = 32'd50; srcB = 32'd3;
        @(negedge clk);
        kill = 1'b0; start = 1'b0;
        check_value("killstart_ready", {63'h0, ready}, 64'h1);
        repeat (40) @(negedge clk);
        check_value("killstart_result", {32'h0, result}, {32'h0, last_result});

        // Reset mid-operation: outputs return to reset values, no done
        c = cyc;
        start = 1'b1; op = 3'b101; srcA = 32'd1000; srcB = 32'd3;
        @(negedge clk);
        start = 1'b0;
        while (cyc < c + 20) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        last_result = 32'h0;
        check_value("midrst_ready",  {63'h0, ready}, 64'h1);
        check_value("midrst_done",   {63'h0, done}, 64'h0);
        check_value("midrst_result", {32'h0, result}, 64'h0);
        repeat (40) @(negedge clk);

        run_op("post_rst", 3'b000, 32'd12, 32'd12, 32'd144, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
